// File: rtl/latch_bank_write_ctrl.sv
// Round-robin write controller for a latch-based register bank: arbitrates two
// requesters and sequences per-row EN/nEN with setup, pulse and hold phases.
module latch_bank_write_ctrl #(
    parameter int ROWS      = 8,
    parameter int WIDTH     = 8,
    parameter int AW        = 4,
    parameter int PULSE_CYC = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [AW-1:0]    ADDR0,
    input  logic [AW-1:0]    ADDR1,
    input  logic [WIDTH-1:0] DATA0,
    input  logic [WIDTH-1:0] DATA1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             ACK0,
    output logic             ACK1,
    output logic             ERR,
    output logic [WIDTH-1:0] WDATA,
    output logic [ROWS-1:0]  EN,
    output logic [ROWS-1:0]  nEN
);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_e;

    localparam logic [AW:0]     ROWS_LIM = (AW+1)'(ROWS);
    localparam logic [2:0]      CNT_LOAD = 3'(PULSE_CYC - 1);
    localparam logic [ROWS-1:0] ROW0     = {{(ROWS-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic             oor_q, oor_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [ROWS-1:0]  en_q, en_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             err_q, err_d;
    logic             pick;
    logic [AW-1:0]    pick_addr;

    // On a tie the requester that was not granted last wins; a lone request always wins.
    always_comb begin
        pick      = REQ1 & (~REQ0 | ~last_q);
        pick_addr = pick ? ADDR1 : ADDR0;

        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        oor_d   = oor_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        en_d    = '0;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (REQ0 | REQ1) begin
                    state_d = SETUP;
                    last_d  = pick;
                    owner_d = pick;
                    addr_d  = pick_addr;
                    oor_d   = ({1'b0, pick_addr} >= ROWS_LIM);
                    wdata_d = pick ? DATA1 : DATA0;
                    gnt0_d  = ~pick;
                    gnt1_d  = pick;
                end
            end
            SETUP: begin
                state_d = PULSE;
                cnt_d   = CNT_LOAD;
                en_d    = oor_q ? '0 : (ROW0 << addr_q);
            end
            PULSE: begin
                // EN is dropped on the same edge that enters HOLD, so data never moves under an open latch.
                if (cnt_q == 3'd0) begin
                    state_d = HOLD;
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    err_d   = oor_q;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                    en_d  = en_q;
                end
            end
            HOLD: begin
                state_d = IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            en_q    <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            oor_q   <= oor_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            en_q    <= en_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
        end
    end

    // nEN comes from the very same flops as EN, so the pair can never agree.
    assign EN    = en_q;
    assign nEN   = ~en_q;
    assign WDATA = wdata_q;
    assign GNT0  = gnt0_q;
    assign GNT1  = gnt1_q;
    assign ACK0  = ack0_q;
    assign ACK1  = ack1_q;
    assign ERR   = err_q;

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Self-checking bench for latch_bank_write_ctrl: three parameterisations share
// one set of requester inputs; directed scenarios plus a randomized model check.
module tb_latch_bank_write_ctrl;

    localparam int WIDTH  = 8;
    localparam int AW     = 4;
    localparam int ROWS_A = 8;
    localparam int P_A    = 2;
    localparam int ROWS_B = 6;
    localparam int P_B    = 1;
    localparam int ROWS_C = 8;
    localparam int P_C    = 7;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic REQ0 = 1'b0;
    logic REQ1 = 1'b0;
    logic [AW-1:0]    ADDR0 = '0;
    logic [AW-1:0]    ADDR1 = '0;
    logic [WIDTH-1:0] DATA0 = '0;
    logic [WIDTH-1:0] DATA1 = '0;

    logic gnt0_a, gnt1_a, ack0_a, ack1_a, err_a;
    logic gnt0_b, gnt1_b, ack0_b, ack1_b, err_b;
    logic gnt0_c, gnt1_c, ack0_c, ack1_c, err_c;
    logic [WIDTH-1:0]  wdata_a, wdata_b, wdata_c;
    logic [ROWS_A-1:0] en_a, nen_a;
    logic [ROWS_B-1:0] en_b, nen_b;
    logic [ROWS_C-1:0] en_c, nen_c;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    latch_bank_write_ctrl #(.ROWS(ROWS_A), .WIDTH(WIDTH), .AW(AW), .PULSE_CYC(P_A)) dut_a (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1),
        .DATA0(DATA0), .DATA1(DATA1), .GNT0(gnt0_a), .GNT1(gnt1_a), .ACK0(ack0_a),
        .ACK1(ack1_a), .ERR(err_a), .WDATA(wdata_a), .EN(en_a), .nEN(nen_a));

    latch_bank_write_ctrl #(.ROWS(ROWS_B), .WIDTH(WIDTH), .AW(AW), .PULSE_CYC(P_B)) dut_b (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1),
        .DATA0(DATA0), .DATA1(DATA1), .GNT0(gnt0_b), .GNT1(gnt1_b), .ACK0(ack0_b),
        .ACK1(ack1_b), .ERR(err_b), .WDATA(wdata_b), .EN(en_b), .nEN(nen_b));

    latch_bank_write_ctrl #(.ROWS(ROWS_C), .WIDTH(WIDTH), .AW(AW), .PULSE_CYC(P_C)) dut_c (
        .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1),
        .DATA0(DATA0), .DATA1(DATA1), .GNT0(gnt0_c), .GNT1(gnt1_c), .ACK0(ack0_c),
        .ACK1(ack1_c), .ERR(err_c), .WDATA(wdata_c), .EN(en_c), .nEN(nen_c));

    // Transaction-level reference for dut_a: a write occupies phases 0..P_A+1 after its grant.
    logic             m_busy, m_owner, m_last;
    int               m_phase;
    logic [AW-1:0]    m_addr;
    logic [WIDTH-1:0] m_wdata;

    function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_busy  <= 1'b0;
            m_phase <= 0;
            m_last  <= 1'b1;
            m_owner <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (!m_busy) begin
            if (REQ0 || REQ1) begin
                m_busy  <= 1'b1;
                m_phase <= 0;
                m_owner <= rr_pick(REQ0, REQ1, m_last);
                m_last  <= rr_pick(REQ0, REQ1, m_last);
                m_addr  <= rr_pick(REQ0, REQ1, m_last) ? ADDR1 : ADDR0;
                m_wdata <= rr_pick(REQ0, REQ1, m_last) ? DATA1 : DATA0;
            end
        end else if (m_phase == P_A + 1) begin
            m_busy <= 1'b0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    // Invariants on every DUT, every cycle.
    logic [WIDTH-1:0] pw_a, pw_b, pw_c;

    always @(negedge CLK) begin
        checks++;
        if (nen_a !== ~en_a || $countones(en_a) > 1) begin
            errors++;
            $display("[TB] FAIL inv_en_a: EN=%h nEN=%h, required nEN=~EN and EN one-hot or zero", en_a, nen_a);
        end
        checks++;
        if (nen_b !== ~en_b || $countones(en_b) > 1) begin
            errors++;
            $display("[TB] FAIL inv_en_b: EN=%h nEN=%h, required nEN=~EN and EN one-hot or zero", en_b, nen_b);
        end
        checks++;
        if (nen_c !== ~en_c || $countones(en_c) > 1) begin
            errors++;
            $display("[TB] FAIL inv_en_c: EN=%h nEN=%h, required nEN=~EN and EN one-hot or zero", en_c, nen_c);
        end
        if (en_a != 0) begin
            checks++;
            if (wdata_a !== pw_a) begin
                errors++;
                $display("[TB] FAIL inv_wdata_a: WDATA=%h while EN=%h, required unchanged %h", wdata_a, en_a, pw_a);
            end
        end
        if (en_b != 0) begin
            checks++;
            if (wdata_b !== pw_b) begin
                errors++;
                $display("[TB] FAIL inv_wdata_b: WDATA=%h while EN=%h, required unchanged %h", wdata_b, en_b, pw_b);
            end
        end
        if (en_c != 0) begin
            checks++;
            if (wdata_c !== pw_c) begin
                errors++;
                $display("[TB] FAIL inv_wdata_c: WDATA=%h while EN=%h, required unchanged %h", wdata_c, en_c, pw_c);
            end
        end
        pw_a <= wdata_a;
        pw_b <= wdata_b;
        pw_c <= wdata_c;
    end

    task automatic apply_reset();
        RST   = 1'b1;
        REQ0  = 1'b0;
        REQ1  = 1'b0;
        ADDR0 = '0;
        ADDR1 = '0;
        DATA0 = '0;
        DATA1 = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        REQ0  = 1'b1;
        ADDR0 = 4'd2;
        DATA0 = 8'h77;
        repeat (2) @(negedge CLK);
        RST  = 1'b1;
        REQ0 = 1'b0;
        #1;
        checks++;
        if ({gnt0_a, gnt1_a, ack0_a, ack1_a, err_a} !== 5'b0 || en_a !== 8'h00 || nen_a !== 8'hFF || wdata_a !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_a: ctl=%b EN=%h nEN=%h WDATA=%h, required 00000 00 FF 00",
                     {gnt0_a, gnt1_a, ack0_a, ack1_a, err_a}, en_a, nen_a, wdata_a);
        end
        checks++;
        if ({gnt0_b, gnt1_b, ack0_b, ack1_b, err_b} !== 5'b0 || en_b !== 6'h00 || nen_b !== 6'h3F || wdata_b !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_b: ctl=%b EN=%h nEN=%h WDATA=%h, required 00000 00 3F 00",
                     {gnt0_b, gnt1_b, ack0_b, ack1_b, err_b}, en_b, nen_b, wdata_b);
        end
        checks++;
        if ({gnt0_c, gnt1_c, ack0_c, ack1_c, err_c} !== 5'b0 || en_c !== 8'h00 || nen_c !== 8'hFF || wdata_c !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_c: ctl=%b EN=%h nEN=%h WDATA=%h, required 00000 00 FF 00",
                     {gnt0_c, gnt1_c, ack0_c, ack1_c, err_c}, en_c, nen_c, wdata_c);
        end
    endtask

    task automatic test_single_write();
        logic       exp_gnt, exp_ack;
        logic [7:0] exp_en;
        apply_reset();
        REQ0  = 1'b1;
        ADDR0 = 4'd3;
        DATA0 = 8'hA5;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLK);
            exp_gnt = (c <= 4);
            exp_ack = (c == 4);
            exp_en  = (c == 2 || c == 3) ? 8'h08 : 8'h00;
            checks++;
            if (gnt0_a !== exp_gnt || gnt1_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_gnt cycle %0d: GNT0=%b GNT1=%b, required %b 0", c, gnt0_a, gnt1_a, exp_gnt);
            end
            checks++;
            if (en_a !== exp_en || nen_a !== ~exp_en) begin
                errors++;
                $display("[TB] FAIL single_en cycle %0d: EN=%h nEN=%h, required %h %h", c, en_a, nen_a, exp_en, ~exp_en);
            end
            checks++;
            if (wdata_a !== 8'hA5) begin
                errors++;
                $display("[TB] FAIL single_wdata cycle %0d: WDATA=%h, required a5", c, wdata_a);
            end
            checks++;
            if (ack0_a !== exp_ack || ack1_a !== 1'b0 || err_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL single_ack cycle %0d: ACK0=%b ACK1=%b ERR=%b, required %b 0 0", c, ack0_a, ack1_a, err_a, exp_ack);
            end
            if (ack0_a) REQ0 = 1'b0;
        end
    endtask

    task automatic test_tie_fairness();
        int         n0, n1, s, ph;
        logic       in_seq, own, e_g0, e_g1, e_a0, e_a1;
        logic [7:0] e_en, e_wd;
        apply_reset();
        n0 = 0;
        n1 = 0;
        REQ0  = 1'b1;
        REQ1  = 1'b1;
        ADDR0 = 4'd1;
        ADDR1 = 4'd6;
        DATA0 = 8'h11;
        DATA1 = 8'h22;
        for (int c = 1; c <= 21; c++) begin
            @(negedge CLK);
            s      = (c - 1) / 5;
            ph     = (c - 1) % 5;
            in_seq = (s < 4) && (ph < 4);
            own    = s[0];
            e_g0   = in_seq && !own;
            e_g1   = in_seq && own;
            e_a0   = in_seq && ph == 3 && !own;
            e_a1   = in_seq && ph == 3 && own;
            e_en   = (in_seq && (ph == 1 || ph == 2)) ? (own ? 8'h40 : 8'h02) : 8'h00;
            e_wd   = (c < 6 || (c >= 11 && c < 16)) ? 8'h11 : 8'h22;
            checks++;
            if ({gnt0_a, gnt1_a, ack0_a, ack1_a} !== {e_g0, e_g1, e_a0, e_a1}) begin
                errors++;
                $display("[TB] FAIL tie_ctl cycle %0d: GNT0/GNT1/ACK0/ACK1=%b, required %b",
                         c, {gnt0_a, gnt1_a, ack0_a, ack1_a}, {e_g0, e_g1, e_a0, e_a1});
            end
            checks++;
            if (en_a !== e_en || wdata_a !== e_wd) begin
                errors++;
                $display("[TB] FAIL tie_data cycle %0d: EN=%h WDATA=%h, required %h %h", c, en_a, wdata_a, e_en, e_wd);
            end
            if (ack0_a) begin
                REQ0 = 1'b0;
                n0++;
            end else if (!REQ0 && n0 < 2) begin
                REQ0 = 1'b1;
            end
            if (ack1_a) begin
                REQ1 = 1'b0;
                n1++;
            end else if (!REQ1 && n1 < 2) begin
                REQ1 = 1'b1;
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [AW-1:0] addrs [4];
        logic [5:0]    one6, e_en;
        logic          oor;
        addrs = '{4'd0, 4'd5, 4'd6, 4'd7};
        one6  = 6'd1;
        for (int k = 0; k < 4; k++) begin
            apply_reset();
            REQ1  = 1'b1;
            ADDR1 = addrs[k];
            DATA1 = 8'h3C + 8'(k);
            oor   = (int'(addrs[k]) >= ROWS_B);
            for (int c = 1; c <= 4; c++) begin
                @(negedge CLK);
                e_en = (c == 2 && !oor) ? (one6 << addrs[k]) : 6'h00;
                checks++;
                if (en_b !== e_en || nen_b !== ~e_en) begin
                    errors++;
                    $display("[TB] FAIL oor_en addr %0d cycle %0d: EN=%h nEN=%h, required %h %h",
                             addrs[k], c, en_b, nen_b, e_en, ~e_en);
                end
                checks++;
                if ({gnt0_b, gnt1_b, ack0_b, ack1_b, err_b} !== {1'b0, c <= 3, 1'b0, c == 3, c == 3 && oor}) begin
                    errors++;
                    $display("[TB] FAIL oor_ctl addr %0d cycle %0d: GNT0/GNT1/ACK0/ACK1/ERR=%b, required %b",
                             addrs[k], c, {gnt0_b, gnt1_b, ack0_b, ack1_b, err_b},
                             {1'b0, c <= 3, 1'b0, c == 3, c == 3 && oor});
                end
                checks++;
                if (wdata_b !== 8'h3C + 8'(k)) begin
                    errors++;
                    $display("[TB] FAIL oor_wdata addr %0d cycle %0d: WDATA=%h, required %h", addrs[k], c, wdata_b, 8'h3C + 8'(k));
                end
                if (ack1_b) REQ1 = 1'b0;
            end
        end
    endtask

    task automatic test_pulse_width();
        int hi, ack_at;
        apply_reset();
        REQ0  = 1'b1;
        ADDR0 = 4'd0;
        DATA0 = 8'h5A;
        hi     = 0;
        ack_at = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            if (en_b[0]) hi++;
            if (ack0_b && ack_at == 0) ack_at = c;
            if (ack0_b) REQ0 = 1'b0;
        end
        checks++;
        if (hi != P_B || ack_at != 3) begin
            errors++;
            $display("[TB] FAIL pulse1: EN[0] high %0d cycles ACK0 at %0d, required 1 and 3", hi, ack_at);
        end
        apply_reset();
        REQ0  = 1'b1;
        ADDR0 = 4'd0;
        DATA0 = 8'hE7;
        hi     = 0;
        ack_at = 0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge CLK);
            if (en_c[0]) hi++;
            if (ack0_c && ack_at == 0) ack_at = c;
            if (ack0_c) REQ0 = 1'b0;
        end
        checks++;
        if (hi != P_C || ack_at != 9) begin
            errors++;
            $display("[TB] FAIL pulse7: EN[0] high %0d cycles ACK0 at %0d, required 7 and 9", hi, ack_at);
        end
    endtask

    task automatic test_reset_mid_pulse();
        apply_reset();
        REQ0  = 1'b1;
        ADDR0 = 4'd5;
        DATA0 = 8'hC3;
        repeat (3) @(negedge CLK);
        checks++;
        if (en_a !== 8'h20) begin
            errors++;
            $display("[TB] FAIL midrst_pre: EN=%h, required 20", en_a);
        end
        RST  = 1'b1;
        REQ0 = 1'b0;
        #1;
        checks++;
        if (en_a !== 8'h00 || nen_a !== 8'hFF || gnt0_a !== 1'b0 || ack0_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_async: EN=%h nEN=%h GNT0=%b ACK0=%b, required 00 FF 0 0", en_a, nen_a, gnt0_a, ack0_a);
        end
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge CLK);
            checks++;
            if (gnt0_a !== 1'b0 || ack0_a !== 1'b0 || en_a !== 8'h00) begin
                errors++;
                $display("[TB] FAIL midrst_idle cycle %0d: GNT0=%b ACK0=%b EN=%h, required 0 0 00", c, gnt0_a, ack0_a, en_a);
            end
        end
        REQ0 = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            checks++;
            if (ack0_a !== (c == 4) || en_a !== ((c == 2 || c == 3) ? 8'h20 : 8'h00) || wdata_a !== 8'hC3) begin
                errors++;
                $display("[TB] FAIL midrst_reissue cycle %0d: ACK0=%b EN=%h WDATA=%h, required %b %h c3",
                         c, ack0_a, en_a, wdata_a, c == 4, (c == 2 || c == 3) ? 8'h20 : 8'h00);
            end
            if (ack0_a) REQ0 = 1'b0;
        end
    endtask

    task automatic test_random();
        logic       hold, pulse, oor;
        logic [4:0] e_ctl;
        logic [7:0] e_en, one8;
        one8 = 8'd1;
        apply_reset();
        for (int c = 0; c < 800; c++) begin
            @(negedge CLK);
            hold  = m_busy && m_phase == P_A + 1;
            pulse = m_busy && m_phase >= 1 && m_phase <= P_A;
            oor   = int'(m_addr) >= ROWS_A;
            e_ctl = {m_busy && !m_owner, m_busy && m_owner, hold && !m_owner, hold && m_owner, hold && oor};
            e_en  = (pulse && !oor) ? (one8 << m_addr) : 8'h00;
            checks++;
            if ({gnt0_a, gnt1_a, ack0_a, ack1_a, err_a} !== e_ctl) begin
                errors++;
                $display("[TB] FAIL rand_ctl step %0d: GNT0/GNT1/ACK0/ACK1/ERR=%b, required %b",
                         c, {gnt0_a, gnt1_a, ack0_a, ack1_a, err_a}, e_ctl);
            end
            checks++;
            if (en_a !== e_en) begin
                errors++;
                $display("[TB] FAIL rand_en step %0d: EN=%h, required %h", c, en_a, e_en);
            end
            checks++;
            if (wdata_a !== m_wdata) begin
                errors++;
                $display("[TB] FAIL rand_wdata step %0d: WDATA=%h, required %h", c, wdata_a, m_wdata);
            end
            if (ack0_a) begin
                REQ0 = 1'b0;
            end else if (REQ0) begin
                if (gnt0_a && $urandom_range(0, 15) == 0) REQ0 = 1'b0;
            end else if (!gnt0_a && $urandom_range(0, 2) == 0) begin
                REQ0  = 1'b1;
                ADDR0 = 4'($urandom_range(0, 15));
                DATA0 = 8'($urandom);
            end
            if (ack1_a) begin
                REQ1 = 1'b0;
            end else if (REQ1) begin
                if (gnt1_a && $urandom_range(0, 15) == 0) REQ1 = 1'b0;
            end else if (!gnt1_a && $urandom_range(0, 2) == 0) begin
                REQ1  = 1'b1;
                ADDR1 = 4'($urandom_range(0, 15));
                DATA1 = 8'($urandom);
            end
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_single_write();
        test_tie_fairness();
        test_out_of_range();
        test_pulse_width();
        test_reset_mid_pulse();
        test_random();
        repeat (2) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/latch_bank_write_ctrl.md
# latch_bank_write_ctrl

Two-requester write controller for a bank of D-latch words. It arbitrates between two write requesters and drives the shared write-data bus. It sequences the complementary per-row EN/nEN enables with setup and hold margins, so a latch is never transparent while its data is changing. It sits between the pipeline write ports and the latch-based register bank, and it is the only block allowed to drive that bank's EN/nEN lines.

## Interface
- ROWS, default 8: number of latch words in the bank; legal range 2..16.
- WIDTH, default 8: bits per word.
- AW, default 4: address width; must satisfy 2^AW >= ROWS.
- PULSE_CYC, default 2: cycles EN is held high per write; legal range 1..7.

- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- REQ0, REQ1  in  1 each  write request; held high until the matching ACK.
- ADDR0, ADDR1  in  AW each  target row; stable while REQ is high.
- DATA0, DATA1  in  WIDTH each  write data; stable while REQ is high.
- GNT0, GNT1  out  1 each  high from SETUP through HOLD for the granted requester.
- ACK0, ACK1  out  1 each  one-cycle completion pulse, asserted in HOLD.
- ERR  out  1  one-cycle pulse, coincident with ACK, when the address is >= ROWS.
- WDATA  out  WIDTH  shared latch data bus, driving D of every row.
- EN  out  ROWS  per-row latch enable; one-hot or all-zero.
- nEN  out  ROWS  bitwise complement of EN at all times.

## Operation
- States: IDLE, SETUP, PULSE, HOLD.
- IDLE: if any REQ is high, select a winner and go to SETUP. Otherwise stay.
- Arbitration is round-robin:
  - A LAST pointer records the last granted requester.
  - When both REQ lines are high, grant the requester that is not LAST.
  - LAST resets so that REQ0 wins the first tie.
  - LAST updates on every grant.
- SETUP (1 cycle): capture the winner's ADDR and DATA into internal registers, drive WDATA, assert GNT, keep EN all-zero.
- PULSE (PULSE_CYC cycles): assert EN[addr] and deassert nEN[addr]; WDATA is unchanged.
  - A 3-bit down-counter loaded with PULSE_CYC-1 sets the duration.
  - Go to HOLD when the counter reaches 0.
- Out-of-range address (addr >= ROWS): PULSE still lasts PULSE_CYC cycles, but EN stays all-zero.
- HOLD (1 cycle):
  - EN is all-zero and WDATA is unchanged.
  - Assert ACK of the granted requester; also assert ERR if the write was out of range.
  - Then go to IDLE.
- The requester must drop REQ on the cycle after it samples ACK. If REQ is still high in IDLE, it is treated as a new request.
- GNT deasserts on entry to IDLE. WDATA retains its last value in IDLE.
- The controller never changes WDATA on a cycle in which any EN bit is high.

## Timing
- All outputs are registered. nEN is generated from the same flops as EN (inverted outputs), so no cycle has EN == nEN.
- Request sampled high at edge n:
  - SETUP is active n+1.
  - PULSE is active n+2 .. n+1+PULSE_CYC.
  - HOLD (with ACK) is active n+2+PULSE_CYC.
  - IDLE resumes at n+3+PULSE_CYC.
- Throughput: one write per PULSE_CYC+3 cycles. Default throughput is one write per 5 cycles.
- Reset values: state IDLE, EN all 0, nEN all 1, GNT0/1 0, ACK0/1 0, ERR 0, WDATA 0, LAST = requester 1.
- Reset asserted mid-operation (any state):
  - EN clears and nEN sets immediately (asynchronously).
  - No ACK is issued for the aborted write.
  - The requester must re-issue it.
- A REQ that drops before ACK is a protocol violation and does not abort the sequence. The write completes with the captured ADDR/DATA.
- A REQ from the non-granted requester arriving during a sequence is held off. It is arbitrated in the next IDLE.

## Test plan
- Single write, default params: REQ0=1, ADDR0=3, DATA0=0xA5 at edge 0.
  - Required: GNT0 high in cycles 1-4, WDATA=0xA5 from cycle 1.
  - Required: EN=0x08 and nEN=0xF7 in cycles 2-3.
  - Required: ACK0 in cycle 4 with EN=0; IDLE in cycle 5.
- Tie and fairness: REQ0 and REQ1 both held, with each dropped one cycle after its ACK and then reasserted.
  - Required grant order: 0, 1, 0, 1.
  - Required: ACKs every 5 cycles, with the idle gap between sequences.
- Out-of-range address: ROWS=6, ADDR1=7.
  - Required: EN=0 throughout, and ERR and ACK1 pulse together in HOLD.
- Reset mid-PULSE: assert RST in cycle 3 of a write to row 5.
  - Required: EN=0 and nEN=all-ones before the next edge, no ACK, state IDLE.
  - Required: after RST drops, a re-issued request completes normally.
- PULSE_CYC=1 and PULSE_CYC=7: write to row 0.
  - Required: EN[0] high for exactly 1 and exactly 7 cycles respectively, with ACK at cycle 3 and cycle 9.
- Invariant check across all tests, every cycle:
  - nEN == ~EN.
  - popcount(EN) <= 1.
  - WDATA is stable whenever EN != 0.
